// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcode encodings,
// datapath widths and the packed command record held in the FIFO.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int SEL_W  = 3;

  // ALU select encodings
  localparam logic [SEL_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [SEL_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [SEL_W-1:0] ALU_AND  = 3'b010;
  localparam logic [SEL_W-1:0] ALU_OR   = 3'b011;
  localparam logic [SEL_W-1:0] ALU_XOR  = 3'b100;
  localparam logic [SEL_W-1:0] ALU_NOTA = 3'b101;
  localparam logic [SEL_W-1:0] ALU_SHL  = 3'b110;
  localparam logic [SEL_W-1:0] ALU_SHR  = 3'b111;

  // One buffered command: load flag, ALU select, operand / load value
  typedef struct packed {
    logic              load;
    logic [SEL_W-1:0]  op;
    logic [DATA_W-1:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_acc_sequencer_if.sv
// Command and result streams of the ALU accumulator sequencer.
//
// Handshake rule for both streams: the source raises valid and holds the
// payload stable until the sink's ready is seen high at a rising clock edge;
// a transfer happens exactly on an edge where valid & ready are both high.
// valid never waits on ready; ready may depend on the sink's state only.
interface alu_acc_sequencer_if;
  import alu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_load;
  logic [SEL_W-1:0]  cmd_op;
  logic [DATA_W-1:0] cmd_data;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_carry;
  logic [SEL_W-1:0]  res_op;

  // Command producer / result consumer side
  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data, res_carry, res_op
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data, res_carry, res_op
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Power-of-two depth so the pointers wrap
// naturally; the occupancy counter is one bit wider than the pointers so
// full and empty are distinguishable without a spare slot.
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_acc_sequencer.sv
// Command sequencer and 4-bit accumulator in front of an external
// combinational ALU. Commands flow FIFO -> op register -> result register;
// one command issues per cycle and each result is written back into the
// accumulator, so every op sees the accumulator left by its predecessor.
module alu_acc_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_acc_sequencer_if.slave bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic [DATA_W-1:0] acc,
  output logic              busy
);

  cmd_t              push_cmd;
  cmd_t              head_cmd;
  cmd_t              op_cmd;
  logic              op_valid;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              slot_free;
  logic              execute;
  logic [DATA_W-1:0] wb_value;

  logic [DATA_W-1:0] acc_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_carry_q;
  logic [SEL_W-1:0]  res_op_q;

  // Handshake and issue conditions
  assign push_cmd      = '{load: bus.cmd_load, op: bus.cmd_op, data: bus.cmd_data};
  assign bus.cmd_ready = ~fifo_full;
  assign push          = bus.cmd_valid & ~fifo_full;
  assign slot_free     = ~res_valid_q | bus.res_ready;
  assign execute       = op_valid & slot_free;
  assign pop           = ~fifo_empty & (~op_valid | execute);

  // Loads bypass the ALU result entirely
  assign wb_value = op_cmd.load ? op_cmd.data : alu_out;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_cmd),
    .pop   (pop),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Op register: refilled from the FIFO head, emptied when it issues alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cmd   <= '0;
      op_valid <= 1'b0;
    end else if (pop) begin
      op_cmd   <= head_cmd;
      op_valid <= 1'b1;
    end else if (execute) begin
      op_valid <= 1'b0;
    end
  end

  // Accumulator write-back and result register capture on issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_op_q    <= ALU_ADD;
    end else if (execute) begin
      acc_q       <= wb_value;
      res_valid_q <= 1'b1;
      res_data_q  <= wb_value;
      res_carry_q <= op_cmd.load ? 1'b0 : alu_carry;
      res_op_q    <= op_cmd.load ? ALU_ADD : op_cmd.op;
    end else if (bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  // ALU drive: A is the accumulator, select parks at add when idle
  assign alu_a   = acc_q;
  assign alu_b   = op_cmd.data;
  assign alu_sel = op_valid ? op_cmd.op : ALU_ADD;

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_op    = res_op_q;

  assign acc  = acc_q;
  assign busy = ~fifo_empty | op_valid | res_valid_q;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Directed bench for alu_acc_sequencer. A command-level model turns every
// accepted command into its expected {carry, op, data} result; one monitor
// compares each consumed result against that queue. Literal expectations
// per scenario pin the model itself.
module tb_alu_acc_sequencer;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_acc_sequencer_if bus();

  logic [3:0] alu_a, alu_b, alu_out, acc;
  logic [2:0] alu_sel;
  logic       alu_carry, busy;
  logic [7:0] alu_r;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_acc   = 0;
  int first_acc_edge = -1;
  int first_res_cyc  = -1;

  logic [3:0] m_acc = 4'h0;
  logic [7:0] exp_q[$];
  logic [7:0] seen_q[$];

  alu_acc_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .acc       (acc),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Result of one command as {carry, res_op, data}, from plain arithmetic
  function automatic logic [7:0] model_step(input logic [3:0] a, input logic ld,
                                            input logic [2:0] op, input logic [3:0] b);
    int ia, ib, r;
    logic c;
    ia = int'(a);
    ib = int'(b);
    r  = 0;
    c  = 1'b0;
    if (ld) return {1'b0, 3'b000, b};
    case (op)
      3'd0: r = (ia + ib) % 16;
      3'd1: begin r = (ia - ib + 16) % 16; c = (ia < ib); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 15 - ia;
      3'd6: r = (ia * 2) % 16;
      default: r = ia / 2;
    endcase
    return {c, op, 4'(r)};
  endfunction

  // Stand-in for the external combinational ALU
  assign alu_r     = model_step(alu_a, 1'b0, alu_sel, alu_b);
  assign alu_out   = alu_r[3:0];
  assign alu_carry = alu_r[7];

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_seen(input string name, input int idx, input logic [7:0] exp);
    if (idx < seen_q.size()) begin
      check(name, {24'h0, seen_q[idx]}, {24'h0, exp});
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: result %0d missing, expected %0h", name, idx, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Samples mid-cycle what will transfer at the coming rising edge.
  always @(negedge clk) begin
    logic [7:0] got, e;
    #2;
    if (!rst_n) begin
      exp_q.delete();
      m_acc = 4'h0;
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        got = {bus.res_carry, bus.res_op, bus.res_data};
        seen_q.push_back(got);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL res_unexpected: got %0h with nothing expected (cycle %0d)", got, cyc);
        end else begin
          e = exp_q.pop_front();
          check("res_stream", {24'h0, got}, {24'h0, e});
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        e = model_step(m_acc, bus.cmd_load, bus.cmd_op, bus.cmd_data);
        m_acc = e[3:0];
        exp_q.push_back(e);
        n_acc++;
        if (first_acc_edge < 0) first_acc_edge = cyc + 1;
      end
      if (bus.res_valid && first_res_cyc < 0) first_res_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic ld, input logic [2:0] op, input logic [3:0] data);
    int waited;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    #1;
    waited = 0;
    while (!bus.cmd_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus.cmd_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL cmd_accept_timeout: cmd_ready stayed 0 for %0d cycles", waited);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int waited;
    idle();
    #1;
    waited = 0;
    while (busy && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check({name, "_idle"}, {31'h0, busy}, 32'h0);
    check({name, "_exp_q_empty"}, exp_q.size(), 0);
    check({name, "_acc_model"}, {28'h0, acc}, {28'h0, m_acc});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int rel_cyc;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_data  = 4'h0;
    bus.res_ready = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_load  = 1'($urandom_range(0, 1));
      bus.cmd_op    = 3'($urandom_range(0, 7));
      bus.cmd_data  = 4'($urandom_range(0, 15));
      bus.res_ready = 1'($urandom_range(0, 1));
      #1;
      check("rst_res_valid", {31'h0, bus.res_valid}, 32'h0);
      check("rst_acc", {28'h0, acc}, 32'h0);
      check("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_alu_sel", {29'h0, alu_sel}, 32'h0);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    rst_n = 1'b1;

    // Arithmetic: load 5, add 3, add C; plus first-result latency
    seen_q.delete();
    first_acc_edge = -1;
    first_res_cyc  = -1;
    send_cmd(1'b1, ALU_ADD, 4'h5);
    send_cmd(1'b0, ALU_ADD, 4'h3);
    send_cmd(1'b0, ALU_ADD, 4'hC);
    drain("arith");
    check("arith_latency", first_res_cyc - first_acc_edge, 2);
    check_seen("arith_r0", 0, 8'h05);
    check_seen("arith_r1", 1, 8'h08);
    check_seen("arith_r2", 2, 8'h04);
    check("arith_acc", {28'h0, acc}, 32'h4);

    // Subtract with borrow
    seen_q.delete();
    send_cmd(1'b1, ALU_ADD, 4'h3);
    send_cmd(1'b0, ALU_SUB, 4'h5);
    drain("sub");
    check_seen("sub_r0", 0, 8'h03);
    check_seen("sub_r1", 1, 8'h9E);
    check("sub_acc", {28'h0, acc}, 32'hE);

    // Logic and shifts
    seen_q.delete();
    send_cmd(1'b1, ALU_ADD, 4'h9);
    send_cmd(1'b0, ALU_SHL, 4'h0);
    send_cmd(1'b0, ALU_SHR, 4'h0);
    send_cmd(1'b0, ALU_NOTA, 4'h0);
    drain("logic");
    check_seen("logic_shl", 1, 8'h62);
    check_seen("logic_shr", 2, 8'h71);
    check_seen("logic_not", 3, 8'h5E);
    check("logic_acc", {28'h0, acc}, 32'hE);

    // Back-pressure: 6 accepted, 7th waits until results drain
    seen_q.delete();
    @(negedge clk);
    bus.res_ready = 1'b0;
    n_acc = 0;
    send_cmd(1'b1, ALU_ADD, 4'h1);
    for (int i = 0; i < 5; i++) send_cmd(1'b0, ALU_ADD, 4'h1);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = ALU_ADD;
    bus.cmd_data  = 4'h1;
    repeat (4) @(negedge clk);
    #1;
    check("bp_ready_low", {31'h0, bus.cmd_ready}, 32'h0);
    check("bp_accepted", n_acc, 6);
    check("bp_res_hold_valid", {31'h0, bus.res_valid}, 32'h1);
    check("bp_res_hold_data", {28'h0, bus.res_data}, 32'h1);
    bus.res_ready = 1'b1;
    send_cmd(1'b0, ALU_ADD, 4'h1);
    send_cmd(1'b0, ALU_ADD, 4'h1);
    drain("bp");
    check("bp_total_accepted", n_acc, 8);
    for (int i = 0; i < 8; i++) check_seen("bp_order", i, 8'(i + 1));

    // Async reset with commands in flight
    @(negedge clk);
    bus.res_ready = 1'b0;
    send_cmd(1'b1, ALU_ADD, 4'h2);
    for (int i = 0; i < 4; i++) send_cmd(1'b0, ALU_ADD, 4'h1);
    idle();
    #1;
    check("mid_busy_before", {31'h0, busy}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", {31'h0, bus.res_valid}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_acc", {28'h0, acc}, 32'h0);
    check("mid_rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    check("mid_rst_alu_sel", {29'h0, alu_sel}, 32'h0);
    repeat (2) @(negedge clk);
    seen_q.delete();
    first_acc_edge = -1;
    rel_cyc = cyc;
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b1;
    bus.cmd_op    = ALU_ADD;
    bus.cmd_data  = 4'h7;
    @(posedge clk);
    drain("post_rst");
    check("post_rst_first_edge", first_acc_edge, rel_cyc + 1);
    check("post_rst_count", seen_q.size(), 1);
    check_seen("post_rst_r0", 0, 8'h07);
    check("post_rst_acc", {28'h0, acc}, 32'h7);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_acc_sequencer.md
# alu_acc_sequencer

Command sequencer and accumulator that sits directly upstream of the 4-bit combinational ALU and drives its operand and select inputs. It accepts a stream of ALU commands through a valid/ready handshake and buffers them in a small FIFO. It issues them one per cycle against a 4-bit accumulator, writes each ALU result back into the accumulator, and presents the result on a registered, back-pressurable output stream.

## Interface
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at clk edge
- cmd_load  in  1  1: load accumulator with cmd_data; 0: execute ALU op
- cmd_op  in  3  ALU select (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 shl, 111 shr)
- cmd_data  in  4  B operand, or load value
- alu_a  out  4  to ALU A; always equals acc
- alu_b  out  4  to ALU B; operand register
- alu_sel  out  3  to ALU select; op register, 000 when op register empty
- alu_out  in  4  ALU result, combinational from alu_a/alu_b/alu_sel
- alu_carry  in  1  ALU carry/borrow flag
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid & res_ready at clk edge
- res_data  out  4  result value
- res_carry  out  1  flag captured with result
- res_op  out  3  opcode of the result; 000 for loads
- acc  out  4  current accumulator
- busy  out  1  FIFO non-empty | op register valid | res_valid

## Operation
- Three-stage path: FIFO → op register (op, data, load, valid) → result register.
- Push: cmd_valid & cmd_ready writes {load, op, data} to the FIFO tail. cmd_ready = !fifo_full, combinational from FIFO state only. There is no bypass.
- Slot free: `slot_free = !res_valid | res_ready`.
- Execute: fires when op_valid & slot_free. On that edge:
  - acc ← alu_out, or cmd data for a load.
  - res_data ← the same value.
  - res_carry ← alu_carry for an op, 0 for a load.
  - res_op ← op.
  - res_valid ← 1.
- Load commands never consult the ALU result.
- Pop: the FIFO head moves to the op register when FIFO non-empty & (!op_valid | execute).
- op_valid clears when execute fires with no pop.
- res_valid clears on res_ready & !execute.
- Widths: results are 4 bits, and add overflow is discarded by the ALU. res_carry is passed through unmodified. Only sub produces a nonzero flag (borrow, set when A<B).
- Order is strictly preserved. No command is dropped or duplicated.
- Accumulator dependency is resolved by the serial issue: each op uses acc as updated by the previous command.

## Timing
- Reset (rst_n low, immediate): FIFO empty, op_valid=0, acc=0, res_valid=0, res_data=0, res_carry=0, res_op=0. This gives alu_a=0, alu_b=0, alu_sel=000, busy=0 and cmd_ready=1.
- Latency: command accepted at edge k → op register at k+1 → res_valid high after k+2, when there is no back-pressure.
- Throughput: 1 command/cycle with res_ready held high.
- Full: cmd_ready=0. A push and pop in the same cycle on a full FIFO is not possible, since ready is low.
- Empty: no pop, and op_valid falls after the last execute.
- Back-pressure: with res_ready=0, results hold stable and the op register stalls. The FIFO fills to FIFO_DEPTH. Total accepted before stall = FIFO_DEPTH + 2.
- Simultaneous push/pop on a non-full FIFO: both take effect and the count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: all in-flight commands are discarded and res_valid drops asynchronously. The first push is accepted at the first edge after release.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams ALU_ADD … ALU_SHR (3'b000–3'b111);
  - DATA_W=4 and SEL_W=3.
- Sub-module alu_cmd_fifo:
  - parameterised synchronous FIFO (width 8 = load + op + data, depth FIFO_DEPTH);
  - push/pop/full/empty ports;
  - count register one bit wider than the pointers.
- Top: op register, result register, accumulator, handshake logic.
- The ALU is instantiated beside this block, not inside it.

## Test plan
- Reset: hold rst_n=0 with random inputs → res_valid=0, acc=0, cmd_ready=1, busy=0, alu_sel=000.
- Arithmetic sequence, res_ready=1:
  - stimulus: load 5, add 3, add C;
  - results: 5/c0, 8/c0, 4/c0 (overflow dropped);
  - res_valid first high 2 cycles after the first accept.
- Subtract: load 3, sub 5 → res_data=E, res_carry=1, acc=E.
- Logic/shift: load 9, shl, shr, not → results 2, 1, E; acc=E.
- Back-pressure, FIFO_DEPTH=4, res_ready=0:
  - offer 8 commands → exactly 6 accepted, then cmd_ready=0;
  - release res_ready → 6 results in order, then the remaining 2 accepted.
- Async reset asserted mid-stream with 3 commands buffered:
  - outputs clear without a clock edge;
  - after release, no stale results appear and a new load 7 returns 7.
